spram_ctl: RTL and testbench
============================

# spram_ctl

Byte-addressed request/response front end for one 16K×16 single-port SPRAM macro, sitting directly upstream of it. Accepts byte, 16-bit word and, optionally, 32-bit dword reads and writes from the eForth core over a valid/ready handshake. Translates each request into registered SPRAM strobes (address, data, nibble write mask, WE, CS) and returns read data or a write acknowledgement as a one-cycle response pulse.

## Interface
Parameters:
- none; geometry fixed at 16384 × 16 bits, 32 KB byte address space.

Ports:
- `clk`  in  1  single clock; also drives the SPRAM `CK`.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept; handshake when both high at a rising edge.
- `req_we`  in  1  1 = write, 0 = read.
- `req_size`  in  2  0 byte, 1 word, 2 dword, 3 reserved.
- `req_addr`  in  15  byte address.
- `req_wdata`  in  32  write data, right-aligned.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  32  read data, zero-extended; 0 for writes and errors.
- `rsp_err`  out  1  valid with `rsp_valid`; misaligned or unsupported request.
- `ram_ad`  out  14  to SPRAM `AD`.
- `ram_di`  out  16  to SPRAM `DI`.
- `ram_maskwe`  out  4  to SPRAM `MASKWE`.
- `ram_we`  out  1  to SPRAM `WE`.
- `ram_cs`  out  1  to SPRAM `CS`.
- `ram_do`  in  16  from SPRAM `DO`.

SPRAM `STDBY` and `SLEEP` are tied 0 and `PWROFF_N` is tied 1 at top level, not by this block.

## Operation
- FSM states: IDLE, ACC0, ACC1, CAP. `req_ready` = (state == IDLE) & ~`rst`.
- Word index `w` = `req_addr[14:1]`. Little-endian byte lanes.
  - `req_addr[0]`=0 uses `DI[7:0]`, mask 4'b0011.
  - `req_addr[0]`=1 uses `DI[15:8]`, mask 4'b1100.
- Byte write: `ram_di` = {`req_wdata[7:0]`, `req_wdata[7:0]`}.
- Word access: `req_addr[0]` must be 0. Mask 4'b1111.
- Dword access: `req_addr[0]` must be 0.
  - Low half at `w`, high half at `w+1`.
  - `w+1` wraps modulo 16384, so 0x3FFF is followed by 0x0000.
- Error cases: misaligned request, `req_size`=3, or dword with the feature compiled out.
  - The request is still accepted.
  - No SPRAM access is made.
  - `rsp_valid` = `rsp_err` = 1 in the next cycle, with `rsp_rdata` = 0.
- Read: byte read returns the selected byte in `rsp_rdata[7:0]`; word read returns `[15:0]`; dword read returns {high, low}.
- State transitions:
  - IDLE to ACC0 on a valid, non-error handshake.
  - ACC0: read goes to ACC1 (dword) or CAP; write goes to ACC1 (dword) or IDLE with an ack.
  - ACC1: read goes to CAP; write goes to IDLE with an ack.
  - CAP goes to IDLE with a response.
- SPRAM strobes are registered. `ram_cs` is high only in ACC0 and ACC1. `ram_we` = `req_we` in those states. `ram_maskwe` is 0 whenever `ram_we` is 0.
- Reset (any time): state goes to IDLE; all outputs go to 0 except `req_ready`, which goes to 1 after `rst` falls.
  - An in-flight request is dropped with no response.
  - A dword write aborted after ACC0 leaves the low half written. This is accepted behaviour.

## Timing
Handshake at edge A. Latency counts edges after A.
- Byte/word read:
  - ACC0 in cycle A+1.
  - `ram_do` is captured in CAP, cycle A+2.
  - `rsp_valid` in cycle A+3.
- Dword read:
  - ACC0 in cycle A+1.
  - ACC1 in cycle A+2, which also captures the low half.
  - CAP in cycle A+3.
  - `rsp_valid` in cycle A+4.
- Byte/word write: strobe in cycle A+1; ack `rsp_valid` in cycle A+2.
- Dword write: strobes in cycles A+1 and A+2; ack in cycle A+3.
- Error response: `rsp_valid` in cycle A+1.
- The response cycle is an IDLE cycle: a new request may be accepted in that same cycle (back-to-back). Throughput is one byte/word read per 3 cycles.
- Request fields are sampled only at the handshake; later changes are ignored.

## Configuration
- `SPRAM_DWORD_EN` defined: dword access (`req_size`=2) is supported, and ACC1 exists.
- `SPRAM_DWORD_EN` undefined:
  - `req_size`=2 is an error response.
  - ACC1 and the high-half capture register are not synthesized.
  - `rsp_rdata[31:16]` is constant 0.

## Test plan
- Reset released, then write word 0x1234 at byte addr 0x0010, then read it back: `ram_maskwe`=4'b1111, `ram_ad`=0x0008; read gives `rsp_rdata`=0x00001234, `rsp_valid` 3 cycles after the handshake.
- Byte writes 0xAB to addr 0x0021, then 0xCD to addr 0x0020: masks are 4'b1100 and 4'b0011; a word read of 0x0020 returns 0xABCD.
- Dword write 0xDEADBEEF at addr 0x7FFE (`SPRAM_DWORD_EN`): `ram_ad`=0x3FFF, then 0x0000; a read returns 0xDEADBEEF after 4 cycles; a word read of 0x0000 returns 0xDEAD.
- Word read at odd addr 0x0003, and `req_size`=3: `rsp_err`=1 one cycle later, `rsp_rdata`=0, `ram_cs` never asserted.
- Back-to-back: `req_valid` held high with three reads → accepts in cycles A, A+3, A+6, each response coinciding with the next accept.
- Assert `rst` during ACC1 of a dword read → no `rsp_valid`; all `ram_*` outputs are 0 immediately; `req_ready`=1 one cycle after release.

Source files
------------

// File: rtl/spram_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : spram_ctl
//  Purpose  : Byte-addressed request/response front end for one 16K x 16
//             single-port SPRAM. Turns byte/word(/dword) reads and writes
//             into registered SPRAM strobes and returns a one-cycle response.
//  Ports    : clk, rst (async, active high)
//             req_valid/req_ready/req_we/req_size/req_addr/req_wdata : request
//             rsp_valid/rsp_rdata/rsp_err                           : response
//             ram_ad/ram_di/ram_maskwe/ram_we/ram_cs/ram_do          : SPRAM
//  Config   : SPRAM_DWORD_EN - enables 32-bit dword access (req_size = 2)
//  Revision : 1.0 - initial release
// ============================================================================
module spram_ctl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic [14:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [13:0] ram_ad,
    output logic [15:0] ram_di,
    output logic [3:0]  ram_maskwe,
    output logic        ram_we,
    output logic        ram_cs,
    input  logic [15:0] ram_do
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        CAP  = 2'd3
    } state_t;

    state_t      state_q,      state_d;
    logic [13:0] ram_ad_q,     ram_ad_d;
    logic [15:0] ram_di_q,     ram_di_d;
    logic [3:0]  ram_maskwe_q, ram_maskwe_d;
    logic        ram_we_q,     ram_we_d;
    logic        ram_cs_q,     ram_cs_d;
    logic        rsp_valid_q,  rsp_valid_d;
    logic        rsp_err_q,    rsp_err_d;
    logic [31:0] rsp_rdata_q,  rsp_rdata_d;
    // Latched request attributes, needed after the handshake
    logic        op_we_q,      op_we_d;
    logic [1:0]  op_size_q,    op_size_d;
    logic        op_lane_q,    op_lane_d;
`ifdef SPRAM_DWORD_EN
    logic [15:0] wdata_hi_q,   wdata_hi_d;
    logic [15:0] rdata_lo_q,   rdata_lo_d;
`else
    wire         w_unused_wdata_hi = &{1'b0, req_wdata[31:16]};
`endif

    logic w_req_err;

    always_comb begin
        w_req_err = (req_size == 2'd3) || ((req_size != 2'd0) && req_addr[0]);
`ifndef SPRAM_DWORD_EN
        if (req_size == 2'd2) begin
            w_req_err = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        ram_ad_d     = ram_ad_q;
        ram_di_d     = ram_di_q;
        ram_maskwe_d = 4'b0000;
        ram_we_d     = 1'b0;
        ram_cs_d     = 1'b0;
        rsp_valid_d  = 1'b0;
        rsp_err_d    = 1'b0;
        rsp_rdata_d  = 32'd0;
        op_we_d      = op_we_q;
        op_size_d    = op_size_q;
        op_lane_d    = op_lane_q;
`ifdef SPRAM_DWORD_EN
        wdata_hi_d   = wdata_hi_q;
        rdata_lo_d   = rdata_lo_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (w_req_err) begin
                        // Accepted but never touches the RAM
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d   = ACC0;
                        op_we_d   = req_we;
                        op_size_d = req_size;
                        op_lane_d = req_addr[0];
                        ram_cs_d  = 1'b1;
                        ram_we_d  = req_we;
                        ram_ad_d  = req_addr[14:1];
                        if (req_size == 2'd0) begin
                            // Byte replicated to both lanes; mask picks one
                            ram_di_d = {req_wdata[7:0], req_wdata[7:0]};
                            if (req_we) begin
                                ram_maskwe_d = req_addr[0] ? 4'b1100 : 4'b0011;
                            end
                        end else begin
                            ram_di_d = req_wdata[15:0];
                            if (req_we) begin
                                ram_maskwe_d = 4'b1111;
                            end
                        end
`ifdef SPRAM_DWORD_EN
                        wdata_hi_d = req_wdata[31:16];
`endif
                    end
                end
            end
            ACC0: begin
`ifdef SPRAM_DWORD_EN
                if (op_size_q == 2'd2) begin
                    // Second access for the high half; index wraps at 16K
                    state_d      = ACC1;
                    ram_cs_d     = 1'b1;
                    ram_we_d     = op_we_q;
                    ram_ad_d     = ram_ad_q + 14'd1;
                    ram_di_d     = wdata_hi_q;
                    ram_maskwe_d = op_we_q ? 4'b1111 : 4'b0000;
                end else
`endif
                if (op_we_q) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                end else begin
                    state_d = CAP;
                end
            end
`ifdef SPRAM_DWORD_EN
            ACC1: begin
                // Low half from the ACC0 read is on ram_do now
                rdata_lo_d = ram_do;
                if (op_we_q) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                end else begin
                    state_d = CAP;
                end
            end
`endif
            CAP: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                if (op_size_q == 2'd0) begin
                    rsp_rdata_d = {24'd0, (op_lane_q ? ram_do[15:8] : ram_do[7:0])};
`ifdef SPRAM_DWORD_EN
                end else if (op_size_q == 2'd2) begin
                    rsp_rdata_d = {ram_do, rdata_lo_q};
`endif
                end else begin
                    rsp_rdata_d = {16'd0, ram_do};
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            ram_ad_q     <= 14'd0;
            ram_di_q     <= 16'd0;
            ram_maskwe_q <= 4'd0;
            ram_we_q     <= 1'b0;
            ram_cs_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= 32'd0;
            op_we_q      <= 1'b0;
            op_size_q    <= 2'd0;
            op_lane_q    <= 1'b0;
`ifdef SPRAM_DWORD_EN
            wdata_hi_q   <= 16'd0;
            rdata_lo_q   <= 16'd0;
`endif
        end else begin
            state_q      <= state_d;
            ram_ad_q     <= ram_ad_d;
            ram_di_q     <= ram_di_d;
            ram_maskwe_q <= ram_maskwe_d;
            ram_we_q     <= ram_we_d;
            ram_cs_q     <= ram_cs_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
            op_we_q      <= op_we_d;
            op_size_q    <= op_size_d;
            op_lane_q    <= op_lane_d;
`ifdef SPRAM_DWORD_EN
            wdata_hi_q   <= wdata_hi_d;
            rdata_lo_q   <= rdata_lo_d;
`endif
        end
    end

    assign req_ready  = (state_q == IDLE) & ~rst;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign ram_ad     = ram_ad_q;
    assign ram_di     = ram_di_q;
    assign ram_maskwe = ram_maskwe_q;
    assign ram_we     = ram_we_q;
    assign ram_cs     = ram_cs_q;

endmodule
`default_nettype wire

// File: tb/tb_spram_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spram_ctl
//  Purpose  : Scoreboard bench for spram_ctl with a behavioural SPRAM and a
//             byte-array reference memory.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spram_ctl;

`ifdef SPRAM_DWORD_EN
    localparam bit DW = 1'b1;
`else
    localparam bit DW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [14:0] req_addr = 15'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [13:0] ram_ad;
    logic [15:0] ram_di;
    logic [3:0]  ram_maskwe;
    logic        ram_we;
    logic        ram_cs;
    logic [15:0] ram_do = 16'd0;

    spram_ctl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_ad(ram_ad), .ram_di(ram_di), .ram_maskwe(ram_maskwe),
        .ram_we(ram_we), .ram_cs(ram_cs), .ram_do(ram_do)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SPRAM: nibble-masked write, registered read data
    logic [15:0] mem [0:16383];
    always @(posedge clk) begin
        if (ram_cs) begin
            if (ram_we) begin
                for (int i = 0; i < 4; i++)
                    if (ram_maskwe[i]) mem[ram_ad][4*i +: 4] <= ram_di[4*i +: 4];
            end else begin
                ram_do <= mem[ram_ad];
            end
        end
    end

    // Reference model: flat little-endian byte memory
    logic [7:0] ref_mem [0:32767];

    typedef struct { logic [31:0] rdata; logic err; int hs; int lat; } rsp_t;
    typedef struct { logic [13:0] ad; logic [3:0] m; logic we; logic [15:0] di; } strb_t;
    rsp_t  rq[$];
    strb_t sq[$];

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model(input logic we, input logic [1:0] sz, input logic [14:0] a,
                         input logic [31:0] wd, input int hs);
        rsp_t  r;
        strb_t s;
        int    n;
        r.hs = hs; r.rdata = 32'd0;
        r.err = (sz == 2'd3) || (sz != 2'd0 && a[0]) || (sz == 2'd2 && !DW);
        if (r.err) begin
            r.lat = 1;
        end else begin
            n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
            for (int i = 0; i < n; i++) begin
                if (we) ref_mem[(int'(a) + i) % 32768] = wd[8*i +: 8];
                else    r.rdata[8*i +: 8] = ref_mem[(int'(a) + i) % 32768];
            end
            r.lat = we ? ((n == 4) ? 3 : 2) : ((n == 4) ? 4 : 3);
            s.ad = a[14:1]; s.we = we;
            s.m  = !we ? 4'b0000 : (sz == 2'd0) ? (a[0] ? 4'b1100 : 4'b0011) : 4'b1111;
            s.di = (sz == 2'd0) ? {wd[7:0], wd[7:0]} : wd[15:0];
            sq.push_back(s);
            if (n == 4) begin
                s.ad = a[14:1] + 14'd1;
                s.di = wd[31:16];
                sq.push_back(s);
            end
        end
        rq.push_back(r);
    endtask

    task automatic issue(input logic we, input logic [1:0] sz, input logic [14:0] a,
                         input logic [31:0] wd, output int hs);
        int guard;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_addr = a; req_wdata = wd;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            vectors++; miscompares++;
            $display("FAIL handshake_timeout: got ready=0 expected ready=1 (cycle %0d)", cyc);
            req_valid = 1'b0;
            hs = -1;
            return;
        end
        @(posedge clk);
        #1;
        hs = cyc;
        model(we, sz, a, wd, hs);
        // Scramble fields after the handshake; they must be ignored
        req_we = 1'($urandom); req_size = 2'($urandom);
        req_addr = 15'($urandom); req_wdata = $urandom;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Response monitor
    rsp_t re;
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (rq.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 expected 0 (cycle %0d)", cyc);
            end else begin
                re = rq.pop_front();
                chk("rsp_rdata", rsp_rdata, re.rdata);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, re.err});
                chk("rsp_latency", 32'(cyc - re.hs), 32'(re.lat - 1));
            end
        end
    end

    // Strobe monitor
    strb_t se;
    always @(negedge clk) begin
        if (ram_cs) begin
            if (sq.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL strobe_unexpected: got ram_cs=1 ad=%h expected ram_cs=0 (cycle %0d)", ram_ad, cyc);
            end else begin
                se = sq.pop_front();
                chk("ram_ad", {18'd0, ram_ad}, {18'd0, se.ad});
                chk("ram_we", {31'd0, ram_we}, {31'd0, se.we});
                chk("ram_maskwe", {28'd0, ram_maskwe}, {28'd0, se.m});
                if (se.we) chk("ram_di", {16'd0, ram_di}, {16'd0, se.di});
            end
        end
    end

    int h1, h2, h3, hx, guard;
    logic [1:0]  rsz;
    logic [14:0] raddr;

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 16'd0;
        for (int i = 0; i < 32768; i++) ref_mem[i] = 8'd0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", {31'd0, req_ready}, 32'd0);
        chk("reset_cs", {31'd0, ram_cs}, 32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", {31'd0, req_ready}, 32'd1);

        // Word write/readback
        issue(1'b1, 2'd1, 15'h0010, 32'h0000_1234, hx);
        issue(1'b0, 2'd1, 15'h0010, 32'h0, hx);
        // Byte lanes
        issue(1'b1, 2'd0, 15'h0021, 32'h0000_00AB, hx);
        issue(1'b1, 2'd0, 15'h0020, 32'h0000_00CD, hx);
        issue(1'b0, 2'd1, 15'h0020, 32'h0, hx);
        issue(1'b0, 2'd0, 15'h0021, 32'h0, hx);
`ifdef SPRAM_DWORD_EN
        // Dword with index wrap
        issue(1'b1, 2'd2, 15'h7FFE, 32'hDEAD_BEEF, hx);
        issue(1'b0, 2'd2, 15'h7FFE, 32'h0, hx);
        issue(1'b0, 2'd1, 15'h0000, 32'h0, hx);
`endif
        // Errors
        issue(1'b0, 2'd1, 15'h0003, 32'h0, hx);
        issue(1'b1, 2'd3, 15'h0040, 32'hFFFF_FFFF, hx);
        issue(1'b1, 2'd2, 15'h0041, 32'h1111_2222, hx);
        idle(2);

        // Back-to-back reads with req_valid held high
        issue(1'b0, 2'd1, 15'h0010, 32'h0, h1);
        issue(1'b0, 2'd1, 15'h0020, 32'h0, h2);
        issue(1'b0, 2'd0, 15'h0020, 32'h0, h3);
        chk("b2b_gap1", 32'(h2 - h1), 32'd3);
        chk("b2b_gap2", 32'(h3 - h2), 32'd3);
        idle(4);

        // Reset in the middle of an access
`ifdef SPRAM_DWORD_EN
        issue(1'b0, 2'd2, 15'h0100, 32'h0, hx);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
`else
        issue(1'b0, 2'd1, 15'h0100, 32'h0, hx);
        req_valid = 1'b0;
`endif
        rst = 1'b1;
        #1;
        chk("abort_ram_cs", {31'd0, ram_cs}, 32'd0);
        chk("abort_ram_we", {31'd0, ram_we}, 32'd0);
        chk("abort_ram_ad", {18'd0, ram_ad}, 32'd0);
        chk("abort_ram_di", {16'd0, ram_di}, 32'd0);
        chk("abort_ram_maskwe", {28'd0, ram_maskwe}, 32'd0);
        chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort_ready", {31'd0, req_ready}, 32'd0);
        rq.delete();
        sq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_abort", {31'd0, req_ready}, 32'd1);

        // Randomized traffic
        for (int t = 0; t < 250; t++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: rsz = 2'd0;
                3, 4, 5: rsz = 2'd1;
                6, 7, 8: rsz = 2'd2;
                default: rsz = 2'd3;
            endcase
            case ($urandom_range(0, 3))
                0:       raddr = 15'($urandom);
                1:       raddr = 15'h7FF8 + 15'($urandom_range(0, 7));
                default: raddr = 15'($urandom_range(0, 63));
            endcase
            issue(1'($urandom), rsz, raddr, $urandom, hx);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 3));
        end
        idle(1);

        guard = 0;
        while ((rq.size() != 0 || sq.size() != 0) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_rsp_queue", 32'(rq.size()), 32'd0);
        chk("drain_strobe_queue", 32'(sq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
